// File: rtl/cnn_input_loader.sv
// cnn_input_loader: captures the weight and pixel streams from the pattern
// interface into local buffers, hands each complete image to the CNN core
// with a start/done handshake and serves registered reads of both buffers.
module cnn_input_loader #(
  parameter int DATA_W   = 15,
  parameter int N_WEIGHT = 126,
  parameter int N_PIXEL  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_1,
  input  logic                     in_valid_2,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic        [6:0]        w_raddr,
  output logic signed [DATA_W-1:0] w_rdata,
  input  logic        [5:0]        p_raddr,
  output logic signed [DATA_W-1:0] p_rdata,
  output logic                     weights_ready,
  output logic                     img_start,
  input  logic                     core_done,
  output logic                     busy,
  output logic        [2:0]        err_flags
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_W   = 3'd1;
  localparam logic [2:0] S_WAIT_IMG = 3'd2;
  localparam logic [2:0] S_LOAD_IMG = 3'd3;
  localparam logic [2:0] S_COMPUTE  = 3'd4;

  localparam logic [6:0] WCNT_FULL = 7'(N_WEIGHT);
  localparam logic [5:0] PIX_LAST  = 6'(N_PIXEL - 1);

  logic [2:0]        state;
  logic [6:0]        wcnt;
  logic [5:0]        pcnt;
  logic [DATA_W-1:0] weight_mem [0:N_WEIGHT-1];
  logic [DATA_W-1:0] pixel_mem  [0:N_PIXEL-1];

  logic       w_we;
  logic       p_we;
  logic       pix_reject;
  logic [6:0] w_waddr;
  logic [5:0] p_waddr;

  // The first beat of a burst always lands at index 0; later beats use the counter.
  assign w_waddr = (state == S_LOAD_W)   ? wcnt : 7'd0;
  assign p_waddr = (state == S_LOAD_IMG) ? pcnt : 6'd0;

  // Decide which beats are stored and which pixel beats are rejected this cycle.
  always_comb begin
    w_we       = 1'b0;
    p_we       = 1'b0;
    pix_reject = 1'b0;
    case (state)
      S_IDLE: begin
        w_we       = in_valid_1;
        pix_reject = in_valid_2;
      end
      S_LOAD_W: begin
        w_we       = in_valid_1 && (wcnt < WCNT_FULL);
        pix_reject = in_valid_2;
      end
      S_WAIT_IMG: begin
        w_we       = in_valid_1;
        p_we       = in_valid_2 && !in_valid_1;
        pix_reject = in_valid_2 && in_valid_1;
      end
      S_LOAD_IMG: begin
        p_we       = in_valid_2 && !in_valid_1;
        pix_reject = in_valid_2 && in_valid_1;
      end
      S_COMPUTE: begin
        pix_reject = in_valid_2;
      end
      default: begin
        pix_reject = in_valid_2;
      end
    endcase
  end

  // Buffer writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_we) weight_mem[w_waddr] <= in_data;
    if (p_we) pixel_mem[p_waddr]  <= in_data;
  end

  // Registered read ports; weight addresses past the last word read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_rdata <= '0;
      p_rdata <= '0;
    end else begin
      w_rdata <= (w_raddr < WCNT_FULL) ? weight_mem[w_raddr] : '0;
      p_rdata <= pixel_mem[p_raddr];
    end
  end

  // Load/compute sequencing, handshake outputs and sticky protocol errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wcnt          <= '0;
      pcnt          <= '0;
      weights_ready <= 1'b0;
      img_start     <= 1'b0;
      busy          <= 1'b0;
      err_flags     <= '0;
    end else begin
      img_start <= 1'b0;
      if (pix_reject) err_flags[2] <= 1'b1;
      case (state)
        S_IDLE, S_WAIT_IMG: begin
          if (in_valid_1) begin
            wcnt          <= 7'd1;
            weights_ready <= 1'b0;
            state         <= S_LOAD_W;
          end else if (in_valid_2 && state == S_WAIT_IMG) begin
            pcnt  <= 6'd1;
            busy  <= 1'b1;
            state <= S_LOAD_IMG;
          end
        end
        S_LOAD_W: begin
          if (in_valid_1) begin
            if (wcnt < WCNT_FULL) wcnt <= wcnt + 7'd1;
            else                  err_flags[0] <= 1'b1;
          end else if (wcnt == WCNT_FULL) begin
            weights_ready <= 1'b1;
            state         <= S_WAIT_IMG;
          end else begin
            err_flags[0]  <= 1'b1;
            weights_ready <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_LOAD_IMG: begin
          if (in_valid_1) err_flags[0] <= 1'b1;
          if (!in_valid_2) begin
            err_flags[1] <= 1'b1;
            busy         <= 1'b0;
            pcnt         <= '0;
            state        <= S_WAIT_IMG;
          end else if (p_we) begin
            if (pcnt == PIX_LAST) begin
              img_start <= 1'b1;
              pcnt      <= '0;
              state     <= S_COMPUTE;
            end else begin
              pcnt <= pcnt + 6'd1;
            end
          end
        end
        S_COMPUTE: begin
          if (in_valid_1) err_flags[0] <= 1'b1;
          if (core_done) begin
            busy  <= 1'b0;
            state <= S_WAIT_IMG;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_input_loader.sv
// Directed bench for cnn_input_loader: weight/image loads, read ports,
// short and overlong bursts, rejected beats and a ten-image run.
module tb_cnn_input_loader;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid_1;
  logic               in_valid_2;
  logic signed [14:0] in_data;
  logic        [6:0]  w_raddr;
  logic signed [14:0] w_rdata;
  logic        [5:0]  p_raddr;
  logic signed [14:0] p_rdata;
  logic               weights_ready;
  logic               img_start;
  logic               core_done;
  logic               busy;
  logic        [2:0]  err_flags;

  int checks      = 0;
  int failures    = 0;
  int start_count = 0;
  int starts_before;

  cnn_input_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_1   (in_valid_1),
    .in_valid_2   (in_valid_2),
    .in_data      (in_data),
    .w_raddr      (w_raddr),
    .w_rdata      (w_rdata),
    .p_raddr      (p_raddr),
    .p_rdata      (p_rdata),
    .weights_ready(weights_ready),
    .img_start    (img_start),
    .core_done    (core_done),
    .busy         (busy),
    .err_flags    (err_flags)
  );

  always #5 clk = ~clk;

  // img_start is a one-cycle pulse, so sampling once per cycle counts each pulse once.
  always @(negedge clk) begin
    if (img_start === 1'b1) start_count++;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stream inputs; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic v1, input logic v2, input int data);
    in_valid_1 = v1;
    in_valid_2 = v2;
    in_data    = data[14:0];
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic sendWeights(input int n, input int base);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, base + i);
  endtask

  task automatic sendPixels(input int n, input int base);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, base + i);
  endtask

  task automatic readWeight(input logic [6:0] addr);
    w_raddr = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic readPixel(input logic [5:0] addr);
    p_raddr = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseDone();
    core_done = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    core_done = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    in_data    = '0;
    w_raddr    = '0;
    p_raddr    = '0;
    core_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_wready", int'(weights_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_err", int'(err_flags), 0);
    checkOutput("rst_start", int'(img_start), 0);

    // Full weight load of 0..125
    sendWeights(126, 0);
    checkOutput("wready_during_load", int'(weights_ready), 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("wready_after_load", int'(weights_ready), 1);
    checkOutput("load_err", int'(err_flags), 0);
    readWeight(7'd37);
    checkOutput("w37", int'($signed(w_rdata)), 37);
    readWeight(7'd125);
    checkOutput("w125", int'($signed(w_rdata)), 125);
    readWeight(7'd127);
    checkOutput("w127_zero", int'($signed(w_rdata)), 0);
    readWeight(7'd37);

    // Asynchronous reset asserted between clock edges
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_wready", int'(weights_ready), 0);
    checkOutput("async_wrdata", int'($signed(w_rdata)), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Short weight burst, then a pixel beat while idle
    sendWeights(100, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("short_w_err", int'(err_flags), 3'b001);
    checkOutput("short_w_wready", int'(weights_ready), 0);
    applyStimulus(1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("idle_pix_busy", int'(busy), 0);
    checkOutput("idle_pix_err", int'(err_flags), 3'b101);
    doReset();

    // Full image after a valid weight load
    sendWeights(126, 0);
    applyStimulus(1'b0, 1'b0, 0);
    starts_before = start_count;
    sendPixels(1, -32);
    checkOutput("busy_first_pix", int'(busy), 1);
    sendPixels(62, -31);
    checkOutput("no_start_early", int'(img_start), 0);
    sendPixels(1, 31);
    checkOutput("start_after_64", int'(img_start), 1);
    checkOutput("busy_compute", int'(busy), 1);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("start_pulse_end", int'(img_start), 0);
    checkOutput("start_count_img", start_count - starts_before, 1);
    readPixel(6'd0);
    checkOutput("p0", int'($signed(p_rdata)), -32);
    readPixel(6'd63);
    checkOutput("p63", int'($signed(p_rdata)), 31);
    checkOutput("busy_before_done", int'(busy), 1);
    pulseDone();
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("img_err", int'(err_flags), 0);

    // Short image burst
    starts_before = start_count;
    sendPixels(40, 100);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("short_img_err", int'(err_flags), 3'b010);
    checkOutput("short_img_busy", int'(busy), 0);
    checkOutput("short_img_nostart", start_count - starts_before, 0);
    doReset();

    // Rejected beats during compute, then an overlong weight burst
    sendWeights(126, 0);
    applyStimulus(1'b0, 1'b0, 0);
    sendPixels(64, -32);
    applyStimulus(1'b0, 1'b1, 999);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("compute_pix_err", int'(err_flags), 3'b100);
    applyStimulus(1'b1, 1'b0, 777);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("compute_w_err", int'(err_flags), 3'b101);
    readPixel(6'd0);
    checkOutput("p0_unchanged", int'($signed(p_rdata)), -32);
    readWeight(7'd0);
    checkOutput("w0_unchanged", int'($signed(w_rdata)), 0);
    pulseDone();
    sendWeights(130, 200);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("long_w_wready", int'(weights_ready), 1);
    readWeight(7'd125);
    checkOutput("long_w125", int'($signed(w_rdata)), 325);
    readWeight(7'd0);
    checkOutput("long_w0", int'($signed(w_rdata)), 200);
    checkOutput("long_w_err", int'(err_flags), 3'b101);
    doReset();

    // Ten back-to-back images, core_done 20 cycles after each img_start
    sendWeights(126, 0);
    applyStimulus(1'b0, 1'b0, 0);
    starts_before = start_count;
    for (int k = 0; k < 10; k++) begin
      sendPixels(64, k * 100);
      for (int j = 0; j < 19; j++) applyStimulus(1'b0, 1'b0, 0);
      pulseDone();
    end
    checkOutput("ten_starts", start_count - starts_before, 10);
    checkOutput("ten_err", int'(err_flags), 0);
    checkOutput("ten_busy", int'(busy), 0);
    readPixel(6'd10);
    checkOutput("ten_last_p10", int'($signed(p_rdata)), 910);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
